// File: rtl/jamma_joy_scan_ctrl.sv
// jamma_joy_scan_ctrl
//   Time-multiplexes the shared JAMMA joystick bus between player 1 and
//   player 2 through an external splitter. After each select switch it waits
//   for the bus to settle, then samples the bus. Each player's 8-bit word and
//   the two coin lines are debounced.
// Ports
//   pclk          pixel clock (single domain)
//   reset_n       asynchronous active-low reset
//   scan_en       1 = scanning runs, 0 = park after the current scan
//   jjoy_i[7:0]   raw JJOY bus, active-low, owner given by jselect_o
//   jcoin_i[1:0]  raw coin inputs, active-low
//   kbd_joy_i[5:0] keyboard joystick, active-low, merged into player 1 [5:0]
//   jselect_o     splitter select (0 = player 1, 1 = player 2)
//   joy1_o[7:0]   debounced player 1 word
//   joy2_o[7:0]   debounced player 2 word
//   coin_o[1:0]   debounced coin lines
//   frame_done_o  one-cycle pulse after a full P1+P2 scan is committed
module jamma_joy_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DEBOUNCE_LEN  = 3
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       scan_en,
  input  logic [7:0] jjoy_i,
  input  logic [1:0] jcoin_i,
  input  logic [5:0] kbd_joy_i,
  output logic       jselect_o,
  output logic [7:0] joy1_o,
  output logic [7:0] joy2_o,
  output logic [1:0] coin_o,
  output logic       frame_done_o
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DB_W  = 4;
  // Debounce lanes: [7:0] player 1, [9:8] coins, [17:10] player 2.
  localparam int unsigned LANES = 18;
  localparam int unsigned P1_LANES = 10;

  localparam logic [1:0] ST_SETTLE1 = 2'd0;
  localparam logic [1:0] ST_SAMPLE1 = 2'd1;
  localparam logic [1:0] ST_SETTLE2 = 2'd2;
  localparam logic [1:0] ST_SAMPLE2 = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LEN      = DB_W'(DEBOUNCE_LEN);
  localparam logic [DB_W-1:0]  DB_MAX      = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parked_q, parked_d;
  logic             jsel_q, jsel_d;
  logic             fd_q, fd_d;
  logic             samp1_c, samp2_c;

  logic [LANES-1:0] db_out_q, db_out_d;
  logic [LANES-1:0] db_cand_q, db_cand_d;
  logic [DB_W-1:0]  db_cnt_q [LANES];
  logic [DB_W-1:0]  db_cnt_d [LANES];
  logic [DB_W-1:0]  step_c;
  logic [LANES-1:0] raw_c;
  logic [LANES-1:0] en_c;

  // Scan scheduler state register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SETTLE1;
      cnt_q    <= '0;
      parked_q <= 1'b0;
      jsel_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      parked_q <= parked_d;
      jsel_q   <= jsel_d;
      fd_q     <= fd_d;
    end
  end

  // Scan scheduler next state; scan_en is only looked at when a scan ends
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    parked_d = parked_q;
    jsel_d   = jsel_q;
    fd_d     = 1'b0;
    samp1_c  = 1'b0;
    samp2_c  = 1'b0;
    case (state_q)
      ST_SETTLE1: begin
        jsel_d = 1'b0;
        if (parked_q) begin
          // Held at count zero; release makes counting start next cycle.
          cnt_d = '0;
          if (scan_en) parked_d = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE1: begin
        samp1_c = 1'b1;
        jsel_d  = 1'b1;
        state_d = ST_SETTLE2;
      end
      ST_SETTLE2: begin
        jsel_d = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE2: begin
        samp2_c  = 1'b1;
        jsel_d   = 1'b0;
        fd_d     = 1'b1;
        parked_d = ~scan_en;
        state_d  = ST_SETTLE1;
      end
      default: begin
        state_d = ST_SETTLE1;
        cnt_d   = '0;
      end
    endcase
  end

  // Raw lane values and per-lane sample enables
  assign raw_c = {jjoy_i, jcoin_i, jjoy_i & {2'b11, kbd_joy_i}};
  assign en_c  = {{(LANES-P1_LANES){samp2_c}}, {P1_LANES{samp1_c}}};

  // Debounce state register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      db_out_q  <= '1;
      db_cand_q <= '1;
      for (int unsigned i = 0; i < LANES; i++) db_cnt_q[i] <= '0;
    end else begin
      db_out_q  <= db_out_d;
      db_cand_q <= db_cand_d;
      for (int unsigned i = 0; i < LANES; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Per-bit debounce: a lane flips after DEBOUNCE_LEN consecutive disagreeing samples
  always_comb begin
    db_out_d  = db_out_q;
    db_cand_d = db_cand_q;
    step_c    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (en_c[i]) begin
        if (raw_c[i] == db_out_q[i]) begin
          db_cnt_d[i] = '0;
        end else begin
          if (raw_c[i] == db_cand_q[i]) begin
            step_c = (db_cnt_q[i] == DB_MAX) ? db_cnt_q[i] : db_cnt_q[i] + DB_W'(1);
          end else begin
            db_cand_d[i] = raw_c[i];
            step_c       = DB_W'(1);
          end
          if (step_c >= DB_LEN) begin
            db_out_d[i] = raw_c[i];
            db_cnt_d[i] = '0;
          end else begin
            db_cnt_d[i] = step_c;
          end
        end
      end
    end
  end

  assign jselect_o    = jsel_q;
  assign joy1_o       = db_out_q[7:0];
  assign coin_o       = db_out_q[9:8];
  assign joy2_o       = db_out_q[17:10];
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_jamma_joy_scan_ctrl.sv
// Bench for jamma_joy_scan_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a frame-phase model.
module tb_jamma_joy_scan_ctrl;

  localparam int S = 4;
  localparam int L = 3;
  localparam int LAST_PH = 2 * S + 1;

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scan_en = 1'b1;
  logic [7:0] jjoy_i;
  logic [7:0] p1_val = 8'hFF;
  logic [7:0] p2_val = 8'hFF;
  logic [5:0] kbd_val = 6'h3F;
  logic [1:0] coin_val = 2'b11;
  logic       jselect_o;
  logic [7:0] joy1_o, joy2_o;
  logic [1:0] coin_o;
  logic       frame_done_o;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  // External splitter: bus carries whichever player jselect_o points at
  assign jjoy_i = jselect_o ? p2_val : p1_val;

  jamma_joy_scan_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_LEN(L)) dut (
    .pclk(pclk), .reset_n(reset_n), .scan_en(scan_en),
    .jjoy_i(jjoy_i), .jcoin_i(coin_val), .kbd_joy_i(kbd_val),
    .jselect_o(jselect_o), .joy1_o(joy1_o), .joy2_o(joy2_o),
    .coin_o(coin_o), .frame_done_o(frame_done_o)
  );

  // Reference model: frame phase 0..2S+1, sample points at S and 2S+1,
  // debounce as a streak of consecutive samples that disagree with the output.
  int        m_phase;
  bit        m_parked, m_jsel, m_fd;
  bit [17:0] m_out;
  int        m_streak [18];

  task automatic model_reset();
    m_phase = 0; m_parked = 0; m_jsel = 0; m_fd = 0; m_out = '1;
    for (int i = 0; i < 18; i++) m_streak[i] = 0;
  endtask

  task automatic model_db(input int i, input bit r);
    if (r == m_out[i]) m_streak[i] = 0;
    else begin
      m_streak[i]++;
      if (m_streak[i] >= L) begin
        m_out[i] = r;
        m_streak[i] = 0;
      end
    end
  endtask

  task automatic model_step();
    bit [17:0] raw;
    raw = {p2_val, coin_val, p1_val & {2'b11, kbd_val}};
    m_fd = 0;
    if (m_parked) begin
      if (scan_en) m_parked = 0;
    end else begin
      if (m_phase == S) begin
        for (int i = 0; i < 10; i++) model_db(i, raw[i]);
        m_jsel = 1;
      end
      if (m_phase == LAST_PH) begin
        for (int i = 10; i < 18; i++) model_db(i, raw[i]);
        m_jsel = 0;
        m_fd = 1;
        m_parked = !scan_en;
      end
      m_phase = (m_phase == LAST_PH) ? 0 : m_phase + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge pclk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Continuous comparison against the model on the falling edge
  always @(negedge pclk) begin
    checks++;
    if ({jselect_o, joy1_o, joy2_o, coin_o, frame_done_o} !==
        {m_jsel, m_out[7:0], m_out[17:10], m_out[9:8], m_fd}) begin
      errors++;
      $display("FAIL model t=%0t got sel=%b j1=%h j2=%h c=%b fd=%b exp sel=%b j1=%h j2=%h c=%b fd=%b",
               $time, jselect_o, joy1_o, joy2_o, coin_o, frame_done_o,
               m_jsel, m_out[7:0], m_out[17:10], m_out[9:8], m_fd);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Returns the number of falling edges until frame_done_o is seen (bounded)
  task automatic wait_fd(output int k);
    k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (!frame_done_o && k < 64);
    if (!frame_done_o) begin
      checks++;
      errors++;
      $display("FAIL fd_timeout got=none exp=pulse t=%0t", $time);
    end
  endtask

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [5:0] kbd;
    logic [1:0] coin;
    int         n;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [1:0] ec;
  } vec_t;

  vec_t vt [11];

  initial begin
    int k, lo, hi, early, bad;
    logic [17:0] snap;

    // Each row holds its inputs for n scans, then checks outputs; state carries over.
    vt[0]  = '{8'hFE, 8'h7F, 6'h3F, 2'b11, 2, 8'hFF, 8'hFF, 2'b11};
    vt[1]  = '{8'hFE, 8'h7F, 6'h3F, 2'b11, 1, 8'hFE, 8'h7F, 2'b11};
    vt[2]  = '{8'hFF, 8'hFF, 6'h3B, 2'b11, 3, 8'hFB, 8'hFF, 2'b11};
    vt[3]  = '{8'hFF, 8'hFE, 6'h3B, 2'b11, 1, 8'hFB, 8'hFF, 2'b11};
    vt[4]  = '{8'hFF, 8'hFF, 6'h3B, 2'b11, 1, 8'hFB, 8'hFF, 2'b11};
    vt[5]  = '{8'hFF, 8'hFE, 6'h3B, 2'b11, 2, 8'hFB, 8'hFF, 2'b11};
    vt[6]  = '{8'hFF, 8'hFF, 6'h3B, 2'b11, 1, 8'hFB, 8'hFF, 2'b11};
    vt[7]  = '{8'hFF, 8'hFF, 6'h3B, 2'b10, 2, 8'hFB, 8'hFF, 2'b11};
    vt[8]  = '{8'hFF, 8'hFF, 6'h3B, 2'b10, 1, 8'hFB, 8'hFF, 2'b10};
    vt[9]  = '{8'hFF, 8'hFF, 6'h00, 2'b11, 3, 8'hC0, 8'hFF, 2'b11};
    vt[10] = '{8'h3F, 8'hFF, 6'h3F, 2'b11, 3, 8'h3F, 8'hFF, 2'b11};

    // T1: reset held with the bus toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      p1_val = 8'($urandom);
      p2_val = 8'($urandom);
      chk("reset_state", 32'({jselect_o, joy1_o, joy2_o, coin_o, frame_done_o}),
          32'({1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0}));
    end
    p1_val = 8'hFF;
    p2_val = 8'hFF;
    @(negedge pclk);
    #2 reset_n = 1'b1;

    // T2: select duty and frame period
    wait_fd(k);
    lo = 0; hi = 0; early = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge pclk);
      if (jselect_o) hi++; else lo++;
      if (i > 0 && frame_done_o) early++;
    end
    chk("sel_low_cycles", 32'(lo), 32'd5);
    chk("sel_high_cycles", 32'(hi), 32'd5);
    chk("fd_early", 32'(early), 32'd0);
    wait_fd(k);
    chk("fd_period", 32'(9 + k), 32'd10);

    // T3/T4/T5 and coin/start-bit rows
    for (int v = 0; v < 11; v++) begin
      p1_val = vt[v].p1; p2_val = vt[v].p2; kbd_val = vt[v].kbd; coin_val = vt[v].coin;
      for (int n = 0; n < vt[v].n; n++) wait_fd(k);
      chk($sformatf("vec%0d_joy1", v), 32'(joy1_o), 32'(vt[v].e1));
      chk($sformatf("vec%0d_joy2", v), 32'(joy2_o), 32'(vt[v].e2));
      chk($sformatf("vec%0d_coin", v), 32'(coin_o), 32'(vt[v].ec));
    end

    // T6: drop scan_en mid-SETTLE2, scan completes, then park
    repeat (7) @(negedge pclk);
    chk("park_in_settle2", 32'(jselect_o), 32'd1);
    scan_en = 1'b0;
    wait_fd(k);
    chk("park_finish_lat", 32'(k), 32'd3);
    snap = {joy2_o, coin_o, joy1_o};
    p1_val = 8'h00; p2_val = 8'h00; coin_val = 2'b00;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      if (jselect_o || frame_done_o || {joy2_o, coin_o, joy1_o} != snap) bad++;
    end
    chk("park_frozen", 32'(bad), 32'd0);
    scan_en = 1'b1;
    wait_fd(k);
    chk("unpark_latency", 32'(k), 32'd11);

    // Reset asserted in SAMPLE2 gives no frame pulse
    repeat (9) @(negedge pclk);
    chk("sample2_sel", 32'(jselect_o), 32'd1);
    #2 reset_n = 1'b0;
    @(negedge pclk);
    chk("rst_s2_state", 32'({jselect_o, joy1_o, joy2_o, coin_o, frame_done_o}),
        32'({1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0}));
    #2 reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (frame_done_o) bad++;
    end
    chk("rst_s2_no_fd", 32'(bad), 32'd0);

    // Randomized run, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk);
      if ($urandom_range(0, 39) == 0) p1_val = 8'($urandom);
      if ($urandom_range(0, 39) == 0) p2_val = 8'($urandom);
      if ($urandom_range(0, 39) == 0) kbd_val = 6'($urandom);
      if ($urandom_range(0, 39) == 0) coin_val = 2'($urandom);
      if ($urandom_range(0, 149) == 0) scan_en = ~scan_en;
    end
    scan_en = 1'b1;
    repeat (30) @(negedge pclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
